// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the four-requester mux arbiter.
// Requester count and select width are fixed by the 4:1 mux being shared.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/data/grant bundle between the requesters and the mux arbiter.
interface mux_arbiter_if #(
    parameter int WIDTH = 1
);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   in0;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [WIDTH-1:0]   in3;
    logic [NUM_REQ-1:0] grant;
    logic               select0;
    logic               select1;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               busy;

    modport master (
        output req, in0, in1, in2, in3,
        input  grant, select0, select1, out, out_valid, busy
    );

    modport slave (
        input  req, in0, in1, in2, in3,
        output grant, select0, select1, out, out_valid, busy
    );

endinterface

// File: rtl/mux_arbiter_mux.sv
// Single-bit 4:1 multiplexer; address1 is the MSB of the select pair.
module behavioralMultiplexer (
    output logic out,
    input  logic address0,
    input  logic address1,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3
);

    logic [3:0] inputs;
    logic [1:0] address;

    assign inputs  = {in3, in2, in1, in0};
    assign address = {address1, address0};
    assign out     = inputs[address];

endmodule

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr, wrapping.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of the shared 4:1 mux with bounded hold time and a registered output stream.
// state | meaning
// IDLE  | no owner; grant is zero, select pair holds its last value
// GRANT | one requester owns the mux; hold_q counts its consecutive cycles
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    mux_arbiter_if.slave bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [SEL_W-1:0]   prio_q, prio_nxt;
    logic [HOLD_W-1:0]  hold_q, hold_nxt;
    logic [WIDTH-1:0]   out_q;
    logic               out_valid_q;

    logic [SEL_W-1:0]   idle_idx, rot_idx;
    logic               idle_found, rot_found;
    logic [NUM_REQ-1:0] others;
    logic               hold_max;
    logic [WIDTH-1:0]   mux_out;

    // The owner is never a candidate for rotation, so the search runs over the others only.
    assign others   = bus.req & ~grant_q;
    assign hold_max = (hold_q == HOLD_LAST);

    rr_pick u_pick_idle (
        .req   (bus.req),
        .ptr   (prio_q),
        .idx   (idle_idx),
        .found (idle_found)
    );

    rr_pick u_pick_rot (
        .req   (others),
        .ptr   (sel_q + SEL_W'(1)),
        .idx   (rot_idx),
        .found (rot_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            prio_q  <= '0;
            hold_q  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            sel_q   <= sel_nxt;
            prio_q  <= prio_nxt;
            hold_q  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        sel_nxt   = sel_q;
        prio_nxt  = prio_q;
        hold_nxt  = hold_q;
        case (state)
            IDLE: begin
                if (idle_found) begin
                    state_nxt = GRANT;
                    grant_nxt = onehot(idle_idx);
                    sel_nxt   = idle_idx;
                    prio_nxt  = idle_idx + SEL_W'(1);
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                // Release and hold expiry share one handoff path with no idle bubble.
                if (!bus.req[sel_q] || (hold_max && rot_found)) begin
                    if (rot_found) begin
                        grant_nxt = onehot(rot_idx);
                        sel_nxt   = rot_idx;
                        prio_nxt  = rot_idx + SEL_W'(1);
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (hold_max) begin
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        behavioralMultiplexer u_mux (
            .out      (mux_out[i]),
            .address0 (sel_q[0]),
            .address1 (sel_q[1]),
            .in0      (bus.in0[i]),
            .in1      (bus.in1[i]),
            .in2      (bus.in2[i]),
            .in3      (bus.in3[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= |grant_q;
            if (|grant_q) begin
                out_q <= mux_out;
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.select0   = sel_q[0];
    assign bus.select1   = sel_q[1];
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench: a behavioural arbiter model predicts each edge for a MAX_HOLD=8 and a MAX_HOLD=1 instance.
module tb_mux_arbiter;
    import mux_arb_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic [W-1:0] out;
        logic         ov;
        int           hold;
        int           prio;
    } mdl_t;

    typedef struct {
        int           id;
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic [W-1:0] out;
        logic         ov;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [3:0]   req = '0;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;

    mdl_t ms, mf;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    mux_arbiter_if #(.WIDTH(W)) bus_slow ();
    mux_arbiter_if #(.WIDTH(W)) bus_fast ();

    assign bus_slow.req = req;
    assign bus_slow.in0 = d0;
    assign bus_slow.in1 = d1;
    assign bus_slow.in2 = d2;
    assign bus_slow.in3 = d3;
    assign bus_fast.req = req;
    assign bus_fast.in0 = d0;
    assign bus_fast.in1 = d1;
    assign bus_fast.in2 = d2;
    assign bus_fast.in3 = d3;

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut_slow (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_slow)
    );

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut_fast (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_fast)
    );

    always #5 clk = ~clk;

    function automatic int rr(logic [3:0] r, int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.grant = '0;
        m.sel   = '0;
        m.out   = '0;
        m.ov    = 1'b0;
        m.hold  = 0;
        m.prio  = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int mh, logic [3:0] r, logic [3:0][W-1:0] dv);
        mdl_t       n;
        int         g;
        int         w;
        logic [3:0] oth;
        n = m;
        n.ov = |m.grant;
        if (|m.grant) n.out = dv[m.sel];
        if (m.grant == 4'b0000) begin
            w = rr(r, m.prio);
            if (w >= 0) begin
                n.grant = 4'b0001 << w;
                n.sel   = 2'(w);
                n.hold  = 0;
                n.prio  = (w + 1) % 4;
            end
        end else begin
            g   = int'(m.sel);
            oth = r & ~m.grant;
            w   = rr(oth, (g + 1) % 4);
            if (!r[g] || (m.hold == mh - 1 && w >= 0)) begin
                if (w >= 0) begin
                    n.grant = 4'b0001 << w;
                    n.sel   = 2'(w);
                    n.hold  = 0;
                    n.prio  = (w + 1) % 4;
                end else begin
                    n.grant = 4'b0000;
                end
            end else if (m.hold == mh - 1) begin
                n.hold = 0;
            end else begin
                n.hold = m.hold + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(int id, mdl_t m);
        exp_t e;
        e.id    = id;
        e.grant = m.grant;
        e.sel   = m.sel;
        e.out   = m.out;
        e.ov    = m.ov;
        e.busy  = |m.grant;
        return e;
    endfunction

    task automatic cmp(string name, int id, logic [7:0] got, logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s_%s at %0t: got %0h expected %0h",
                   (id == 0) ? "slow" : "fast", name, $time, got, want);
        end
    endtask

    task automatic check(exp_t e);
        logic [3:0]   g;
        logic [1:0]   s;
        logic [W-1:0] o;
        logic         v;
        logic         b;
        if (e.id == 0) begin
            g = bus_slow.grant;
            s = {bus_slow.select1, bus_slow.select0};
            o = bus_slow.out;
            v = bus_slow.out_valid;
            b = bus_slow.busy;
        end else begin
            g = bus_fast.grant;
            s = {bus_fast.select1, bus_fast.select0};
            o = bus_fast.out;
            v = bus_fast.out_valid;
            b = bus_fast.busy;
        end
        cmp("grant", e.id, 8'(g), 8'(e.grant));
        cmp("select", e.id, 8'(s), 8'(e.sel));
        cmp("out", e.id, 8'(o), 8'(e.out));
        cmp("out_valid", e.id, 8'(v), 8'(e.ov));
        cmp("busy", e.id, 8'(b), 8'(e.busy));
    endtask

    task automatic check_reset_now();
        ms = mdl_reset();
        mf = mdl_reset();
        sb.push_back(to_exp(0, ms));
        sb.push_back(to_exp(1, mf));
        while (sb.size() > 0) check(sb.pop_front());
    endtask

    task automatic cycle(int n);
        logic [3:0][W-1:0] dv;
        repeat (n) begin
            dv = {d3, d2, d1, d0};
            ms = step(ms, 8, req, dv);
            mf = step(mf, 1, req, dv);
            sb.push_back(to_exp(0, ms));
            sb.push_back(to_exp(1, mf));
            @(posedge clk);
            #1;
            while (sb.size() > 0) check(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ms = mdl_reset();
        mf = mdl_reset();
        {d3, d2, d1, d0} = {4'h3, 4'hC, 4'h5, 4'hA};

        // power-on reset
        #2 reset_n = 1'b0;
        #1 check_reset_now();
        @(negedge clk);
        reset_n = 1'b1;

        // reset asserted between edges while requester 2 owns the mux
        req = 4'b0100;
        cycle(3);
        #2 reset_n = 1'b0;
        #1 check_reset_now();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(3);

        // owner 2 releases to idle, then 0 and 2 request together: search from prio 3 wraps to 0
        req = 4'b0000;
        cycle(2);
        req = 4'b0101;
        cycle(3);
        // requester 0 drops: direct handoff to 2 with no valid gap
        req = 4'b0100;
        cycle(3);

        // single requester holds indefinitely
        req = 4'b0000;
        cycle(2);
        {d3, d2, d1, d0} = {4'h0, 4'h0, 4'h1, 4'h0};
        req = 4'b0010;
        cycle(20);

        // full contention: forced rotation every 8 (slow) or every cycle (fast)
        req = 4'b0000;
        cycle(2);
        {d3, d2, d1, d0} = {4'h3, 4'hC, 4'h5, 4'hA};
        req = 4'b1111;
        cycle(40);

        // release coinciding with hold expiry, and random traffic
        req = 4'b1110;
        cycle(10);
        repeat (60) begin
            req = 4'($urandom_range(0, 15));
            {d3, d2, d1, d0} = 16'($urandom);
            cycle(int'($urandom_range(1, 4)));
        end

        req = 4'b0000;
        cycle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
